// File: rtl/alu_seq_mdu.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_mdu
// Description : Registered RISC-V ALU with 1-cycle base ops and iterative RV32M
//               multiply/divide, delivering every result through valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mdu #(
   parameter int WIDTH  = 32,
   parameter bit MDU_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             res31,
   output logic             busy
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam int CNT_W   = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   opnd;
   logic [2:0]         m_sel;
   logic               neg_q;
   logic               neg_a;
   logic               b_zero;

   logic               accept;
   logic               is_m;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   upper_imm;
   logic [WIDTH-1:0]   base_res;
   logic               a_sgn;
   logic               b_sgn;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic               ge;
   logic [WIDTH-1:0]   sub;
   logic [WIDTH-1:0]   acc_nx;
   logic [WIDTH-1:0]   lo_nx;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   mdu_res;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign is_m      = MDU_EN && (op[4:3] == 2'b10);
   assign busy      = (state == CALC);
   assign zero      = (result == '0);
   assign res31     = result[WIDTH-1];

   assign shamt     = b[SHAMT_W-1:0];
   assign upper_imm = {b[WIDTH-1:12], 12'b0};

   always_comb begin
      base_res = '0;
      case (op)
         5'h00:   base_res = a + b;
         5'h01:   base_res = a - b;
         5'h02:   base_res = a & b;
         5'h03:   base_res = a | b;
         5'h04:   base_res = a ^ b;
         5'h05:   base_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         5'h06:   base_res = {{(WIDTH-1){1'b0}}, (a < b)};
         5'h08:   base_res = a + upper_imm;
         5'h09:   base_res = upper_imm;
         5'h0A:   base_res = a << shamt;
         5'h0B:   base_res = $signed(a) >>> shamt;
         5'h0C:   base_res = a >> shamt;
         default: base_res = '0;
      endcase
   end

   // Signedness of each operand: MUL/MULH/DIV/REM signed, MULHSU signed a only.
   assign a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
   assign b_sgn = op[2] ? ~op[0] : ~op[1];
   assign a_neg = a_sgn && a[WIDTH-1];
   assign b_neg = b_sgn && b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // One iteration of shift-add (multiply) or restoring subtract (divide),
   // followed by the sign fix-up used only on the final iteration.
   always_comb begin
      sum     = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      shifted = {acc, lo[WIDTH-1]};
      ge      = (shifted >= {1'b0, opnd});
      sub     = shifted[WIDTH-1:0] - opnd;
      if (m_sel[2]) begin
         acc_nx = ge ? sub : shifted[WIDTH-1:0];
         lo_nx  = {lo[WIDTH-2:0], ge};
      end else begin
         acc_nx = sum[WIDTH:1];
         lo_nx  = {sum[0], lo[WIDTH-1:1]};
      end
      prod = neg_q ? -{acc_nx, lo_nx} : {acc_nx, lo_nx};
      // A zero divisor leaves the quotient all-ones and the dividend in acc.
      quo  = b_zero ? {WIDTH{1'b1}} : (neg_q ? -lo_nx : lo_nx);
      rem  = neg_a ? -acc_nx : acc_nx;
      case (m_sel)
         3'd0:             mdu_res = prod[WIDTH-1:0];
         3'd1, 3'd2, 3'd3: mdu_res = prod[2*WIDTH-1:WIDTH];
         3'd4, 3'd5:       mdu_res = quo;
         default:          mdu_res = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         acc       <= '0;
         lo        <= '0;
         opnd      <= '0;
         m_sel     <= '0;
         neg_q     <= 1'b0;
         neg_a     <= 1'b0;
         b_zero    <= 1'b0;
      end else begin
         case (state)
            CALC: begin
               acc <= acc_nx;
               lo  <= lo_nx;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  result    <= mdu_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               if ((state == DONE) && out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
               if (accept) begin
                  if (is_m) begin
                     acc       <= '0;
                     lo        <= a_mag;
                     opnd      <= b_mag;
                     m_sel     <= op[2:0];
                     neg_q     <= a_neg ^ b_neg;
                     neg_a     <= a_neg;
                     b_zero    <= (b == '0);
                     cnt       <= '0;
                     out_valid <= 1'b0;
                     state     <= CALC;
                  end else begin
                     result    <= base_res;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
         endcase
      end
   end
endmodule
`default_nettype wire
